// File: rtl/sha1_wb_host.sv
// Wishbone classic initiator that runs one 512-bit block through the SHA1 peripheral:
// ID check, engine reset, 16 message writes, DONE poll, 5-word digest read-back.
module sha1_wb_host #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0024,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned POLL_MAX     = 1023
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         start_i,
  input  logic [511:0] message_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o,
  output logic [2:0]   err_code_o,
  output logic [159:0] digest_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic         wbm_ack_i,
  input  logic [31:0]  wbm_dat_i
);
  localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

  localparam logic [31:0] ADR_ID    = BASE_ADDRESS + 32'h0000_0004;
  localparam logic [31:0] ADR_OPS   = BASE_ADDRESS + 32'h0000_0008;
  localparam logic [31:0] ADR_MSG   = BASE_ADDRESS + 32'h0000_000C;
  localparam logic [31:0] ADR_DIG   = BASE_ADDRESS + 32'h0000_0010;
  localparam logic [31:0] ID_VALUE  = 32'h5348_4131;
  localparam logic [31:0] OPS_RESET = 32'h0000_0002;
  localparam logic [31:0] MSG_OK    = 32'h0000_0001;
  localparam logic [31:0] EBUSY     = 32'hFFFF_FFF0;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_ID   = 3'd1;
  localparam logic [2:0] ERR_ACK  = 3'd2;
  localparam logic [2:0] ERR_POLL = 3'd3;
  localparam logic [2:0] ERR_MSG  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ID = 3'd1, S_RST = 3'd2, S_MSG = 3'd3,
    S_POLL = 3'd4, S_DIG = 3'd5, S_FIN = 3'd6
  } state_t;

  state_t              state_r, state_n;
  logic                cyc_r, cyc_n, we_r, we_n;
  logic [31:0]         adr_r, adr_n, dat_r, dat_n;
  logic [ACK_W-1:0]    ack_cnt_r, ack_cnt_n;
  logic [POLL_W-1:0]   poll_cnt_r, poll_cnt_n;
  logic [3:0]          msg_idx_r, msg_idx_n;
  logic [2:0]          dig_idx_r, dig_idx_n;
  logic [511:0]        msg_r, msg_n;
  logic [159:0]        digest_r, digest_n;
  logic [2:0]          err_code_r, err_code_n;
  logic                busy_r, busy_n, done_r, done_n, error_r, error_n;
  logic                req_we_s, abort_s, budget_last_s;
  logic [31:0]         req_adr_s, req_dat_s;
  logic [2:0]          abort_code_s;

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_r <= S_IDLE;
    else          state_r <= state_n;
  end

  // Datapath and output registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_r <= 1'b0; we_r <= 1'b0; adr_r <= 32'h0; dat_r <= 32'h0;
      ack_cnt_r <= '0; poll_cnt_r <= '0; msg_idx_r <= 4'd0; dig_idx_r <= 3'd0;
      msg_r <= 512'h0; digest_r <= 160'h0; err_code_r <= ERR_NONE;
      busy_r <= 1'b0; done_r <= 1'b0; error_r <= 1'b0;
    end else begin
      cyc_r <= cyc_n; we_r <= we_n; adr_r <= adr_n; dat_r <= dat_n;
      ack_cnt_r <= ack_cnt_n; poll_cnt_r <= poll_cnt_n;
      msg_idx_r <= msg_idx_n; dig_idx_r <= dig_idx_n;
      msg_r <= msg_n; digest_r <= digest_n; err_code_r <= err_code_n;
      busy_r <= busy_n; done_r <= done_n; error_r <= error_n;
    end
  end

  // Next-state, bus sequencing and abort handling
  always_comb begin
    state_n = state_r; cyc_n = cyc_r; we_n = we_r; adr_n = adr_r; dat_n = dat_r;
    ack_cnt_n = ack_cnt_r; poll_cnt_n = poll_cnt_r;
    msg_idx_n = msg_idx_r; dig_idx_n = dig_idx_r;
    msg_n = msg_r; digest_n = digest_r; err_code_n = err_code_r;
    busy_n = busy_r; done_n = 1'b0; error_n = 1'b0;
    abort_s = 1'b0; abort_code_s = ERR_NONE;
    budget_last_s = (poll_cnt_r == POLL_LAST);
    req_we_s = 1'b0; req_adr_s = 32'h0; req_dat_s = 32'h0;

    case (state_r)
      S_ID:    req_adr_s = ADR_ID;
      S_RST:   begin req_we_s = 1'b1; req_adr_s = ADR_OPS; req_dat_s = OPS_RESET; end
      S_MSG:   begin req_we_s = 1'b1; req_adr_s = ADR_MSG; req_dat_s = msg_r[{msg_idx_r, 5'd0} +: 32]; end
      S_POLL:  req_adr_s = ADR_OPS;
      S_DIG:   req_adr_s = ADR_DIG;
      default: req_adr_s = 32'h0;
    endcase

    case (state_r)
      S_IDLE: begin
        // A start coinciding with the done/error pulse is dropped, not queued
        if (start_i && !done_r && !error_r) begin
          msg_n = message_i; digest_n = 160'h0; err_code_n = ERR_NONE;
          poll_cnt_n = '0; msg_idx_n = 4'd0; dig_idx_n = 3'd0;
          busy_n = 1'b1; state_n = S_ID;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_FIN: begin
        done_n = 1'b1; busy_n = 1'b0; state_n = S_IDLE;
      end
      S_ID, S_RST, S_MSG, S_POLL, S_DIG: begin
        if (!cyc_r) begin
          cyc_n = 1'b1; we_n = req_we_s; adr_n = req_adr_s; dat_n = req_dat_s;
          ack_cnt_n = '0;
        end else if (wbm_ack_i) begin
          cyc_n = 1'b0; we_n = 1'b0; adr_n = 32'h0; dat_n = 32'h0;
          case (state_r)
            S_ID:
              if (wbm_dat_i != ID_VALUE) begin abort_s = 1'b1; abort_code_s = ERR_ID; end
              else state_n = S_RST;
            S_RST: state_n = S_MSG;
            S_MSG:
              if (wbm_dat_i != MSG_OK) begin abort_s = 1'b1; abort_code_s = ERR_MSG; end
              else begin
                msg_idx_n = msg_idx_r + 4'd1;
                if (msg_idx_r == 4'd15) state_n = S_POLL;
                else                    state_n = S_MSG;
              end
            S_POLL:
              if (wbm_dat_i[3]) state_n = S_DIG;
              else if (budget_last_s) begin abort_s = 1'b1; abort_code_s = ERR_POLL; end
              else poll_cnt_n = poll_cnt_r + POLL_W'(1'b1);
            S_DIG:
              // EBUSY re-reads the same word and draws on the poll budget
              if (wbm_dat_i == EBUSY) begin
                if (budget_last_s) begin abort_s = 1'b1; abort_code_s = ERR_POLL; end
                else poll_cnt_n = poll_cnt_r + POLL_W'(1'b1);
              end else begin
                digest_n[{dig_idx_r, 5'd0} +: 32] = wbm_dat_i;
                if (dig_idx_r == 3'd4) state_n = S_FIN;
                else                   dig_idx_n = dig_idx_r + 3'd1;
              end
            default: state_n = S_IDLE;
          endcase
        end else if (ack_cnt_r == ACK_LAST) begin
          abort_s = 1'b1; abort_code_s = ERR_ACK;
        end else begin
          ack_cnt_n = ack_cnt_r + ACK_W'(1'b1);
        end
      end
      default: begin
        state_n = S_IDLE; busy_n = 1'b0; cyc_n = 1'b0;
      end
    endcase

    if (abort_s) begin
      state_n = S_IDLE; cyc_n = 1'b0; we_n = 1'b0; adr_n = 32'h0; dat_n = 32'h0;
      busy_n = 1'b0; error_n = 1'b1; err_code_n = abort_code_s;
    end else begin
      error_n = 1'b0;
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign error_o    = error_r;
  assign err_code_o = err_code_r;
  assign digest_o   = digest_r;
  assign wbm_cyc_o  = cyc_r;
  assign wbm_stb_o  = cyc_r;
  assign wbm_we_o   = we_r;
  assign wbm_sel_o  = cyc_r ? 4'hF : 4'h0;
  assign wbm_adr_o  = adr_r;
  assign wbm_dat_o  = dat_r;

endmodule

// File: tb/tb_sha1_wb_host.sv
// Directed bench for sha1_wb_host against a scripted SHA1 Wishbone slave.
module tb_sha1_wb_host;
  localparam logic [31:0] A_ID  = 32'h3000_0028;
  localparam logic [31:0] A_OPS = 32'h3000_002C;
  localparam logic [31:0] A_MSG = 32'h3000_0030;
  localparam logic [31:0] A_DIG = 32'h3000_0034;
  localparam logic [159:0] DIG_EXP = {32'h55555555, 32'h44444444, 32'h33333333,
                                      32'h22222222, 32'h11111111};

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b0;
  logic         start_i = 1'b0;
  logic [511:0] message_i = 512'h0;
  logic         busy_o, done_o, error_o;
  logic [2:0]   err_code_o;
  logic [159:0] digest_o;
  logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o, wbm_dat_o;
  logic         wbm_ack_i = 1'b0;
  logic [31:0]  wbm_dat_i = 32'h0;

  sha1_wb_host #(.BASE_ADDRESS(32'h3000_0024), .ACK_TIMEOUT(16), .POLL_MAX(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .message_i(message_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_code_o(err_code_o),
    .digest_o(digest_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Slave script knobs (written by the stimulus only)
  logic        slv_clr = 1'b1;
  logic [31:0] id_val = 32'h5348_4131;
  int          done_on = 3;
  int          noack_at = -1;
  logic        ebusy_en = 1'b0;

  // Slave state and access log (written by the slave only)
  int          n_acc = 0, msg_cnt = 0, ops_reads = 0, dig_cnt = 0;
  logic        ebusy_given = 1'b0;
  logic [64:0] log_acc [0:63];

  // Scripted slave: registered ack one cycle after stb, one ack per access
  always @(posedge wb_clk_i) begin
    if (slv_clr) begin
      n_acc <= 0; msg_cnt <= 0; ops_reads <= 0; dig_cnt <= 0;
      ebusy_given <= 1'b0; wbm_ack_i <= 1'b0; wbm_dat_i <= 32'h0;
    end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i &&
                 !(wbm_we_o && wbm_adr_o == A_MSG && msg_cnt == noack_at)) begin
      wbm_ack_i <= 1'b1;
      if (n_acc < 64) log_acc[n_acc] <= {wbm_we_o, wbm_adr_o, wbm_dat_o};
      n_acc <= n_acc + 1;
      wbm_dat_i <= 32'h0;
      if (wbm_we_o) begin
        wbm_dat_i <= 32'h1;
        if (wbm_adr_o == A_MSG) msg_cnt <= msg_cnt + 1;
      end else if (wbm_adr_o == A_ID) begin
        wbm_dat_i <= id_val;
      end else if (wbm_adr_o == A_OPS) begin
        ops_reads <= ops_reads + 1;
        wbm_dat_i <= (ops_reads + 1 == done_on) ? 32'h8 : 32'h0;
      end else if (wbm_adr_o == A_DIG) begin
        if (ebusy_en && !ebusy_given) begin
          wbm_dat_i <= 32'hFFFF_FFF0; ebusy_given <= 1'b1;
        end else begin
          wbm_dat_i <= 32'h1111_1111 * (dig_cnt + 1); dig_cnt <= dig_cnt + 1;
        end
      end
    end else begin
      wbm_ack_i <= 1'b0;
    end
  end

  // Pulse and bus-shape monitor, cumulative counters
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0, bus_bad = 0;
  int   cur_len = 0, last_len = 0;
  logic done_q = 1'b0, error_q = 1'b0;
  always @(negedge wb_clk_i) begin
    if (done_o) done_cnt <= done_cnt + 1;
    if (error_o) err_cnt <= err_cnt + 1;
    if (done_o && error_o) both_cnt <= both_cnt + 1;
    if ((done_o && done_q) || (error_o && error_q)) long_cnt <= long_cnt + 1;
    if ((wbm_stb_o !== wbm_cyc_o) || (wbm_cyc_o && wbm_sel_o !== 4'hF)) bus_bad <= bus_bad + 1;
    done_q <= done_o; error_q <= error_o;
    if (wbm_cyc_o) cur_len <= cur_len + 1;
    else begin
      if (cur_len != 0) last_len <= cur_len;
      cur_len <= 0;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [511:0] make_msg();
    logic [511:0] m;
    m = 512'h0;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = 32'h0101_0101 * (i + 1);
    return m;
  endfunction

  function automatic logic [64:0] exp_acc(input int j, input int ops_n);
    logic [31:0] w;
    w = 32'h0101_0101 * (j - 1);
    if (j == 0)               return {1'b0, A_ID, 32'h0};
    else if (j == 1)          return {1'b1, A_OPS, 32'h2};
    else if (j < 18)          return {1'b1, A_MSG, w};
    else if (j < 18 + ops_n)  return {1'b0, A_OPS, 32'h0};
    else                      return {1'b0, A_DIG, 32'h0};
  endfunction

  task automatic clr_slave();
    slv_clr = 1'b1;
    @(negedge wb_clk_i);
    slv_clr = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where done_o or error_o is seen
  task automatic run(input logic [511:0] msg, input int budget, input int pulse_at, output bit ended);
    ended = 1'b0;
    message_i = msg; start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0; message_i = ~msg;
    for (int c = 0; c < budget && !ended; c++) begin
      start_i = (c == pulse_at);
      @(negedge wb_clk_i);
      if (done_o || error_o) ended = 1'b1;
    end
    start_i = 1'b0;
  endtask

  bit ended, found;
  int d0, e0;

  initial begin
    #1 wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    check("rst_ctl", {busy_o, done_o, error_o, err_code_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 160'h0);
    check("rst_bus", {wbm_adr_o, wbm_dat_o}, 160'h0);
    check("rst_dig", digest_o, 160'h0);
    wb_rst_i = 1'b0;
    clr_slave();

    // Nominal block, with a stray start while busy
    d0 = done_cnt; e0 = err_cnt;
    run(make_msg(), 500, 5, ended);
    check("t1_end", ended, 1'b1);
    check("t1_done", {done_o, error_o, busy_o}, 3'b100);
    @(negedge wb_clk_i);
    check("t1_nacc", n_acc, 26);
    for (int j = 0; j < 26; j++) check($sformatf("t1_acc%0d", j), log_acc[j], exp_acc(j, 3));
    check("t1_ops", ops_reads, 3);
    check("t1_dig", digest_o, DIG_EXP);
    check("t1_code", err_code_o, 3'd0);
    check("t1_pulses", {done_cnt - d0, err_cnt - e0}, {32'd1, 32'd0});

    // Wrong peripheral ID
    id_val = 32'hDEAD_BEEF;
    clr_slave();
    run(make_msg(), 200, -1, ended);
    check("t2_end", {ended, error_o, done_o, busy_o, wbm_cyc_o}, 5'b11000);
    check("t2_code", err_code_o, 3'd1);
    @(negedge wb_clk_i);
    check("t2_nacc", n_acc, 1);
    check("t2_acc0", log_acc[0], {1'b0, A_ID, 32'h0});
    check("t2_dig", digest_o, 160'h0);

    // No ack on the 5th message write
    id_val = 32'h5348_4131; noack_at = 4;
    clr_slave();
    run(make_msg(), 200, -1, ended);
    check("t3_end", {ended, error_o, busy_o, wbm_cyc_o}, 4'b1100);
    check("t3_code", err_code_o, 3'd2);
    @(negedge wb_clk_i);
    check("t3_stb_len", last_len, 16);
    check("t3_nacc", n_acc, 6);

    // DONE never set, poll budget of 8
    noack_at = -1; done_on = 0;
    clr_slave();
    run(make_msg(), 500, -1, ended);
    check("t4_end", {ended, error_o, busy_o}, 3'b110);
    check("t4_code", err_code_o, 3'd3);
    @(negedge wb_clk_i);
    check("t4_ops", ops_reads, 8);
    check("t4_nacc", n_acc, 26);

    // EBUSY on the first digest read is retried
    done_on = 1; ebusy_en = 1'b1;
    clr_slave();
    run(make_msg(), 500, -1, ended);
    check("t5_end", {ended, done_o, error_o}, 3'b110);
    @(negedge wb_clk_i);
    check("t5_nacc", n_acc, 25);
    check("t5_acc19", log_acc[19], {1'b0, A_DIG, 32'h0});
    check("t5_dig", digest_o, DIG_EXP);
    check("t5_code", err_code_o, 3'd0);

    // Reset during message word 7, then a clean rerun
    done_on = 3; ebusy_en = 1'b0;
    clr_slave();
    e0 = err_cnt;
    message_i = make_msg(); start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge wb_clk_i);
      if (msg_cnt == 7 && wbm_cyc_o) found = 1'b1;
    end
    check("t6_reach_w7", found, 1'b1);
    wb_rst_i = 1'b1;
    #1;
    check("t6_rst_bus", {wbm_cyc_o, wbm_stb_o, busy_o}, 3'b000);
    repeat (2) @(negedge wb_clk_i);
    check("t6_rst_code", {err_code_o, error_o}, 4'h0);
    check("t6_no_err", err_cnt - e0, 0);
    wb_rst_i = 1'b0;
    clr_slave();
    run(make_msg(), 500, -1, ended);
    check("t6_end", {ended, done_o}, 2'b11);
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge wb_clk_i);
    check("t6_acc0", log_acc[0], {1'b0, A_ID, 32'h0});
    check("t6_nacc", n_acc, 26);
    check("t6_dig", digest_o, DIG_EXP);
    check("t6_start_on_done", {busy_o, wbm_cyc_o}, 2'b00);

    check("pulse_excl", both_cnt, 0);
    check("pulse_len", long_cnt, 0);
    check("bus_shape", bus_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
